gshare_branch_predictor: RTL and testbench

- Fetch-side next-PC predictor. It replaces the fixed current_pc+4 guess that feeds the IF next-PC mux.
- Combines a direct-mapped BTB (tag, target, is_cond) with a gshare PHT of 2-bit saturating counters and a global history register (BHR).
- Looks up combinationally from the IF-stage PC. Trains from branch/jump resolution in EX.
- The PHT index used at fetch is exported so the pipeline can carry it through IF/ID and ID/EX and return it at update.

---
 rtl/gshare_branch_predictor.sv | 95 +++++++++
 tb/tb_gshare_branch_predictor.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_branch_predictor.sv
// gshare next-PC predictor: direct-mapped BTB plus a PHT of 2-bit counters
// indexed by (PC index XOR global history).
// Ports:
//   clk, reset                - clock, asynchronous active-high reset
//   current_pc                - IF-stage PC to predict from
//   predicted_pc, pred_index  - combinational prediction and the PHT index used
//   update_*                  - resolution from EX (one pulse per branch/jump)
module gshare_branch_predictor #(
    parameter int unsigned INDEX_BITS   = 5,
    parameter int unsigned HISTORY_BITS = 5  // 1 <= HISTORY_BITS <= INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           current_pc,
    output logic [31:0]           predicted_pc,
    output logic [INDEX_BITS-1:0] pred_index,
    input  logic                  update_enable,
    input  logic [31:0]           update_pc,
    input  logic [INDEX_BITS-1:0] update_index,
    input  logic                  update_is_cond,
    input  logic                  update_taken,
    input  logic [31:0]           update_target
);

    localparam int unsigned ENTRIES  = 2 ** INDEX_BITS;
    localparam int unsigned TAG_BITS = 32 - INDEX_BITS - 2;

    logic [ENTRIES-1:0]      btb_valid;
    logic [ENTRIES-1:0]      btb_is_cond;
    logic [TAG_BITS-1:0]     btb_tag    [ENTRIES];
    logic [31:0]             btb_target [ENTRIES];
    logic [1:0]              pht        [ENTRIES];
    logic [HISTORY_BITS-1:0] bhr;

    logic [INDEX_BITS-1:0]   bidx;
    logic [TAG_BITS-1:0]     lookup_tag;
    logic [INDEX_BITS-1:0]   uidx;
    logic [31:0]             pc_plus4;
    logic                    hit;
    logic                    pred_taken;
    logic                    unused_pc_bits;

    // Lookup: pure combinational read of pre-update state
    assign bidx         = current_pc[INDEX_BITS+1:2];
    assign lookup_tag   = current_pc[31:INDEX_BITS+2];
    assign pred_index   = bidx ^ INDEX_BITS'(bhr);
    assign hit          = !reset && btb_valid[bidx] && (btb_tag[bidx] == lookup_tag);
    assign pred_taken   = hit && (!btb_is_cond[bidx] || pht[pred_index][1]);
    assign pc_plus4     = current_pc + 32'd4;
    assign predicted_pc = pred_taken ? btb_target[bidx] : pc_plus4;

    assign uidx           = update_pc[INDEX_BITS+1:2];
    assign unused_pc_bits = ^update_pc[1:0];

    // PHT counters and history advance only on resolved conditional branches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                pht[i] <= 2'b01;
            end
            bhr <= '0;
        end else if (update_enable && update_is_cond) begin
            if (update_taken) begin
                if (pht[update_index] != 2'b11) begin
                    pht[update_index] <= pht[update_index] + 2'd1;
                end
            end else begin
                if (pht[update_index] != 2'b00) begin
                    pht[update_index] <= pht[update_index] - 2'd1;
                end
            end
            // Truncating {bhr, taken} drops the oldest bit; also covers HISTORY_BITS=1
            bhr <= HISTORY_BITS'({bhr, update_taken});
        end
    end

    // BTB valid bits: the only BTB state that needs clearing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btb_valid <= '0;
        end else if (update_enable && update_taken) begin
            btb_valid[uidx] <= 1'b1;
        end
    end

    // BTB payload: written on taken resolution, meaningless while invalid
    always_ff @(posedge clk) begin
        if (update_enable && update_taken && !reset) begin
            btb_tag[uidx]     <= update_pc[31:INDEX_BITS+2];
            btb_target[uidx]  <= update_target;
            btb_is_cond[uidx] <= update_is_cond;
        end
    end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Randomized and directed bench for gshare_branch_predictor against a
// behavioural model built from arrays and integer arithmetic.
module tb_gshare_branch_predictor;

    localparam int unsigned IB = 5;
    localparam int unsigned N  = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   current_pc = '0;
    logic [31:0]   predicted_pc;
    logic [IB-1:0] pred_index;
    logic          update_enable = 1'b0;
    logic [31:0]   update_pc = '0;
    logic [IB-1:0] update_index = '0;
    logic          update_is_cond = 1'b0;
    logic          update_taken = 1'b0;
    logic [31:0]   update_target = '0;

    int vectors = 0;
    int miscompares = 0;
    bit checking = 1'b0;

    // Model state
    bit          mv    [N];
    logic [31:0] mtag  [N];
    logic [31:0] mtgt  [N];
    bit          mcond [N];
    int          mpht  [N];
    int          mbhr;

    always #5 clk = ~clk;

    gshare_branch_predictor #(.INDEX_BITS(5), .HISTORY_BITS(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .current_pc     (current_pc),
        .predicted_pc   (predicted_pc),
        .pred_index     (pred_index),
        .update_enable  (update_enable),
        .update_pc      (update_pc),
        .update_index   (update_index),
        .update_is_cond (update_is_cond),
        .update_taken   (update_taken),
        .update_target  (update_target)
    );

    function automatic void model_clear();
        for (int i = 0; i < int'(N); i++) begin
            mv[i]   = 1'b0;
            mpht[i] = 1;
        end
        mbhr = 0;
    endfunction

    function automatic void model_predict(input logic [31:0] pc, output logic [31:0] epc,
                                          output int eidx);
        int b;
        b    = int'((pc / 4) % 32);
        eidx = b ^ mbhr;
        epc  = pc + 32'd4;
        if (mv[b] && mtag[b] == pc / 128 && (!mcond[b] || mpht[eidx] >= 2)) epc = mtgt[b];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reset clears the model immediately
    always @(posedge reset) model_clear();

    // Model training on the clock edge
    always @(posedge clk) begin
        if (!reset && update_enable) begin
            int ub, ui;
            ub = int'((update_pc / 4) % 32);
            ui = int'(update_index);
            if (update_is_cond) begin
                if (update_taken && mpht[ui] < 3) mpht[ui] = mpht[ui] + 1;
                else if (!update_taken && mpht[ui] > 0) mpht[ui] = mpht[ui] - 1;
                mbhr = (mbhr * 2 + int'(update_taken)) % 32;
            end
            if (update_taken) begin
                mv[ub]    = 1'b1;
                mtag[ub]  = update_pc / 128;
                mtgt[ub]  = update_target;
                mcond[ub] = update_is_cond;
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (checking) begin
            logic [31:0] epc;
            int eidx;
            if (reset) begin
                epc  = current_pc + 32'd4;
                eidx = int'((current_pc / 4) % 32);
            end else begin
                model_predict(current_pc, epc, eidx);
            end
            chk("cyc_pc", predicted_pc, epc);
            chk("cyc_idx", 32'(pred_index), 32'(eidx));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input int idx, input bit cond, input bit tk,
                       input logic [31:0] tgt);
        update_enable  = 1'b1;
        update_pc      = pc;
        update_index   = IB'(idx);
        update_is_cond = cond;
        update_taken   = tk;
        update_target  = tgt;
    endtask

    task automatic look(input string name, input logic [31:0] pc, input logic [31:0] epc,
                        input int eidx);
        current_pc = pc;
        #1;
        chk({name, "_pc"}, predicted_pc, epc);
        chk({name, "_idx"}, 32'(pred_index), 32'(eidx));
    endtask

    function automatic logic [31:0] rand_pc();
        logic [24:0] t;
        case ($urandom_range(0, 2))
            0:       t = '0;
            1:       t = 25'd1;
            default: t = '1;
        endcase
        return {t, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3))};
    endfunction

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checking = 1'b1;

        // Basic lookup and PC wrap
        look("rst_lookup", 32'h10, 32'h14, 4);
        look("wrap", 32'hFFFF_FFFC, 32'h0, 31);

        // Unconditional install, then alias miss
        upd(32'h40, 0, 1'b0, 1'b1, 32'h100);
        tick();
        update_enable = 1'b0;
        look("jal_hit", 32'h40, 32'h100, 16);
        look("alias", 32'h840, 32'h844, 16);

        // Reset mid-cycle takes hold before the next edge
        reset = 1'b1;
        look("rst_mid", 32'h40, 32'h44, 16);
        tick();
        reset = 1'b0;
        look("rst_after", 32'h40, 32'h44, 16);
        tick();

        // Same-cycle update is not bypassed
        upd(32'h40, 0, 1'b0, 1'b1, 32'h100);
        look("same_cyc", 32'h40, 32'h44, 16);
        tick();
        update_enable = 1'b0;
        look("next_cyc", 32'h40, 32'h100, 16);

        // Two conditional taken at index 0
        upd(32'h0C, 0, 1'b1, 1'b1, 32'h80);
        tick();
        tick();
        update_enable = 1'b0;
        look("cond_tk", 32'h0C, 32'h80, 0);

        // Two not-taken: BTB entry kept, new index 15
        upd(32'h0C, 0, 1'b1, 1'b0, 32'h999);
        tick();
        tick();
        update_enable = 1'b0;
        look("cond_nt", 32'h0C, 32'h10, 15);

        // Saturation of pht[7]
        upd(32'h1C, 20, 1'b1, 1'b1, 32'h300);
        tick();
        upd(32'h60, 7, 1'b1, 1'b1, 32'h200);
        repeat (5) tick();
        update_enable = 1'b0;
        look("sat_hi", 32'h60, 32'h200, 7);
        upd(32'h60, 7, 1'b1, 1'b0, 32'h0);
        repeat (6) tick();
        update_enable = 1'b0;
        look("sat_lo", 32'h1C, 32'h20, 7);
        look("hist_clr", 32'h60, 32'h64, 24);
        tick();

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            reset          = ($urandom_range(0, 199) == 0);
            current_pc     = rand_pc();
            update_enable  = ($urandom_range(0, 1) == 1);
            update_pc      = rand_pc();
            update_index   = IB'($urandom_range(0, 31));
            update_is_cond = ($urandom_range(0, 2) != 0);
            update_taken   = update_is_cond ? ($urandom_range(0, 1) == 1) : 1'b1;
            update_target  = $urandom;
            tick();
        end
        reset = 1'b0;
        update_enable = 1'b0;
        tick();
        checking = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
